// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Holds the FSM state encoding, the BCD digit width and each digit's maximum value.
// Imported by stopwatch_core and bcd_digit_counter.
package stopwatch_pkg;

    localparam int BCD_DIGIT_WIDTH = 4;

    localparam int DIGIT_MAX_HUNDREDTHS = 9;
    localparam int DIGIT_MAX_TENTHS     = 9;
    localparam int DIGIT_MAX_SECONDS    = 9;
    localparam int DIGIT_MAX_TENS       = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX and wraps, with a carry pulse on wrap.
// Latency: the digit updates on the edge after inc; carry_out is combinational (inc & digit==MAX).
// Backpressure: none. clr is synchronous and takes priority over inc.
// Ports: clk, rst_n, inc, clr -> digit[3:0], carry_out
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inc,
    input  logic                       clr,
    output logic [BCD_DIGIT_WIDTH-1:0] digit,
    output logic                       carry_out
);

    localparam logic [BCD_DIGIT_WIDTH-1:0] DIGIT_MAX = BCD_DIGIT_WIDTH'(MAX);

    logic at_max;

    assign at_max    = (digit == DIGIT_MAX);
    assign carry_out = inc & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= at_max ? '0 : digit + BCD_DIGIT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core. It runs an IDLE/RUNNING/PAUSED FSM from button rising edges and prescales clk to a tick.
// It also drives a 4-digit BCD SS.hh count, with an optional frozen lap display selected by STOPWATCH_LAP_EN.
// Latency: a button edge acts on the edge it is first sampled; tick and number update on the same edge. Backpressure: none.
// Ports: clk, rst_n, start_stop, lap, clear -> number[15:0], running, lap_active, overflow, tick
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int TICK_FREQUENCY_IN_HZ        = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] number,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic        tick
);

    localparam int DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    generate
        if ((DIV < 2) || ((BOARD_CLOCK_FREQUENCY_IN_HZ % TICK_FREQUENCY_IN_HZ) != 0)) begin : g_bad_div
            $error("stopwatch_core: clock/tick ratio must be an integer >= 2");
        end
    endgenerate

    sw_state_t     state, state_nxt;
    logic          ss_q, clr_q;
    logic [PW-1:0] presc;
    logic          ss_go, clr_go, presc_adv, tick_now;
    logic [15:0]   count;
    logic [3:0]    carry;

    // Events that would have no effect in the current state do not pre-empt
    // lower-priority events: clear only acts in PAUSED, so clear+start_stop
    // while RUNNING still pauses.
    always_comb begin
        state_nxt = state;
        clr_go    = 1'b0;
        ss_go     = 1'b0;
        presc_adv = 1'b0;
        tick_now  = 1'b0;
        clr_go    = clear & ~clr_q & (state == PAUSED);
        ss_go     = start_stop & ~ss_q & ~clr_go;
        case (state)
            IDLE: begin
                if (ss_go) state_nxt = RUNNING;
            end
            RUNNING: begin
                // The prescaler freezes on the pausing edge so a resume
                // continues the partially elapsed tick period.
                presc_adv = ~ss_go;
                tick_now  = ~ss_go & (presc == PRESC_MAX);
                if (ss_go) state_nxt = PAUSED;
            end
            PAUSED: begin
                if (clr_go)     state_nxt = IDLE;
                else if (ss_go) state_nxt = RUNNING;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ss_q     <= 1'b0;
            clr_q    <= 1'b0;
            presc    <= '0;
            tick     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            ss_q  <= start_stop;
            clr_q <= clear;
            tick  <= tick_now;
            if (clr_go) begin
                presc <= '0;
            end else if (presc_adv) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
            end
            if (clr_go)        overflow <= 1'b0;
            else if (carry[3]) overflow <= 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX_HUNDREDTHS)) u_hundredths (
        .clk(clk), .rst_n(rst_n), .inc(tick_now), .clr(clr_go),
        .digit(count[3:0]), .carry_out(carry[0])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_TENTHS)) u_tenths (
        .clk(clk), .rst_n(rst_n), .inc(carry[0]), .clr(clr_go),
        .digit(count[7:4]), .carry_out(carry[1])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_SECONDS)) u_seconds (
        .clk(clk), .rst_n(rst_n), .inc(carry[1]), .clr(clr_go),
        .digit(count[11:8]), .carry_out(carry[2])
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_tens (
        .clk(clk), .rst_n(rst_n), .inc(carry[2]), .clr(clr_go),
        .digit(count[15:12]), .carry_out(carry[3])
    );

    assign running = (state == RUNNING);

`ifdef STOPWATCH_LAP_EN
    logic        lap_q;
    logic        lap_go;
    logic [15:0] lap_reg;

    // lap only acts when neither start_stop nor clear acted on this edge.
    assign lap_go = lap & ~lap_q & ~ss_go & ~clr_go & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q      <= 1'b0;
            lap_reg    <= '0;
            lap_active <= 1'b0;
        end else begin
            lap_q <= lap;
            if (clr_go) begin
                lap_reg    <= '0;
                lap_active <= 1'b0;
            end else if (lap_go) begin
                // Capture only from RUNNING; the registered count is the
                // pre-increment value even when a tick lands on this edge.
                if (lap_active) begin
                    lap_active <= 1'b0;
                end else if (state == RUNNING) begin
                    lap_reg    <= count;
                    lap_active <= 1'b1;
                end
            end
        end
    end

    assign number = lap_active ? lap_reg : count;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign number     = count;
`endif

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping core of the stopwatch: sits between the button debouncers and the four-digit display driver. It takes debounced start/stop, lap and clear button levels, runs a start/pause/idle state machine, and divides the board clock down to a 100 Hz tick. It advances a four-digit BCD SS.hh count (00.00–59.99) and presents either the live count or a frozen lap value on a 16-bit packed-BCD `number` bus, consumed directly by the digit display.

## Interface
- `BOARD_CLOCK_FREQUENCY_IN_HZ`, 100_000_000, input clock frequency.
- `TICK_FREQUENCY_IN_HZ`, 100, count rate. `DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ` must be an integer ≥ 2; otherwise elaboration fails.
- `clk` in 1: single system clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: debounced level; the rising edge is the event.
- `lap` in 1: debounced level; the rising edge is the event.
- `clear` in 1: debounced level; the rising edge is the event.
- `number` out 16: packed BCD, [15:12] tens of seconds, [11:8] seconds, [7:4] tenths, [3:0] hundredths.
- `running` out 1: high in RUNNING.
- `lap_active` out 1: high while `number` shows the frozen lap value.
- `overflow` out 1: sticky; set on wrap from 59.99.
- `tick` out 1: one-cycle pulse on each count increment.

## Operation
- Edge detect: each button input has a prior-sample register, and `evt = in & ~in_q`. Priority within one cycle is clear > start_stop > lap; a lower-priority event in the same cycle is dropped.
- **IDLE** (reset state): count, prescaler and lap register are zero.
  - start_stop → RUNNING.
  - lap and clear have no effect.
- **RUNNING**:
  - The prescaler counts 0..DIV-1. At DIV-1 it returns to 0, `tick` pulses and the count increments.
  - start_stop → PAUSED; the prescaler holds its value.
  - lap with `lap_active`=0: capture the count into the lap register and set `lap_active`.
  - lap with `lap_active`=1: clear `lap_active`.
  - clear is ignored.
- **PAUSED**: count and prescaler hold.
  - start_stop → RUNNING; the prescaler resumes from its held value.
  - lap clears `lap_active`; it never captures.
  - clear → IDLE: zero the count, prescaler and lap register; clear `lap_active` and `overflow`.
- Digit limits:
  - Hundredths 0–9, carry to tenths.
  - Tenths 0–9, carry to seconds.
  - Seconds 0–9, carry to tens of seconds.
  - Tens of seconds 0–5.
  - Increment at 59.99 → 00.00 and `overflow`←1. The count keeps running.
- `number = lap_active ? lap_reg : count`.
- Reset values: state IDLE, `number`=16'h0000, and `running`, `lap_active`, `overflow`, `tick` all 0.

## Timing
- A button input first sampled high at clock edge k takes effect at edge k. For example, `running` is high after edge k.
- A held button produces exactly one event. It must return low for at least one cycle before it can produce another event.
- First tick after IDLE→RUNNING at edge k lands at edge k+DIV. `tick` is high for the cycle after that edge.
- Count and `tick` update on the same edge. `number` reflects the new count with zero added latency.
- A lap capture on the same edge as a tick captures the pre-increment count.
- `rst_n` low at any time forces the reset values immediately (asynchronous). Deassertion is synchronized externally.

## Configuration
- `STOPWATCH_LAP_EN` defined: the lap register, `lap_active` and lap handling are as above.
- `STOPWATCH_LAP_EN` undefined: no lap register is built and the `lap` input is ignored. `lap_active` is tied to 0 and `number` always shows the live count.

## Structure
- Shared package `stopwatch_pkg`:
  - State enum `sw_state_t` (IDLE, RUNNING, PAUSED).
  - Digit maximum constants `DIGIT_MAX_HUNDREDTHS`=9, `DIGIT_MAX_TENTHS`=9, `DIGIT_MAX_SECONDS`=9, `DIGIT_MAX_TENS`=5.
  - BCD digit width constant = 4.
- One sub-module, `bcd_digit_counter`:
  - Parameter MAX.
  - Inputs: inc, clr.
  - Outputs: 4-bit digit, carry_out (inc & digit==MAX).
  - Four instances are chained in the core.
- Prescaler width: `$clog2(DIV)`.

## Test plan
All scenarios use `BOARD_CLOCK_FREQUENCY_IN_HZ`=1000 and `TICK_FREQUENCY_IN_HZ`=100, so DIV=10.
- Reset, then a start_stop pulse at edge k → `running`=1 after k. First `tick` at k+10. `number`=16'h0001 after k+10, and 16'h0010 after k+100.
- Run to 16'h5999, then one more tick → `number`=16'h0000, `overflow`=1, `running` stays 1.
- Lap at count 16'h0123 → `number` frozen at 0123 while the internal count advances. A second lap → `number` shows the live count.
- start_stop mid-prescaler (value 4) → PAUSED and hold. After 50 idle cycles, start_stop again → next tick exactly 6 cycles later.
- Simultaneous rising edges of clear and start_stop in PAUSED → IDLE, `number`=0, `overflow`=0, `running`=0. The same pair in RUNNING → PAUSED, with the count unchanged.
- Assert `rst_n`=0 mid-count with `lap_active`=1 → all outputs 0 immediately. Build with `STOPWATCH_LAP_EN` undefined → lap pulses never change `number`.
